// File: rtl/lif_pkg.sv
// Shared types, default widths and saturating arithmetic for the LIF spike decoder.
package lif_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int unsigned LIF_CNT_W = 8;
    localparam int unsigned LIF_WIN_W = 8;
    localparam int unsigned LIF_ISI_W = 8;

    // value + inc clamped at max; callers keep value <= max
    function automatic logic [31:0] sat_inc(
        input logic [31:0] value,
        input logic [31:0] inc,
        input logic [31:0] max
    );
        logic [32:0] sum;
        sum = 33'(value) + 33'(inc);
        return (sum >= 33'(max)) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_sat_counter.sv
// Saturating up-counter with synchronous clear and restart-at-one.
module lif_sat_counter
    import lif_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         start,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic [W-1:0] next_c,
    output logic         sat_c
);

    localparam logic [31:0] MAX = 32'((64'd1 << W) - 64'd1);

    assign next_c = W'(sat_inc(32'(value), 32'(inc), MAX));
    assign sat_c  = (32'(next_c) == MAX);

    // clear wins over start; start loads 1 so a fresh interval counts its first cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (start) begin
            value <= W'(1);
        end else begin
            value <= next_c;
        end
    end

endmodule

// File: rtl/lif_spike_decoder.sv
// Converts a LIF spike train into a windowed firing rate and an inter-spike interval.
module lif_spike_decoder
    import lif_pkg::*;
#(
    parameter int unsigned CNT_W = LIF_CNT_W,
    parameter int unsigned WIN_W = LIF_WIN_W,
    parameter int unsigned ISI_W = LIF_ISI_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic             rate_sat,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid
);

    state_t             state_q;
    state_t             state_d;
    logic               spike_q;
    logic [WIN_W-1:0]   wlen_q;
    logic [WIN_W-1:0]   wc_q;
    logic [WIN_W-1:0]   wlen_in_c;
    logic               has_prev_q;

    logic               active_c;
    logic               win_end_c;
    logic               latch_c;
    logic               rise_c;

    logic [CNT_W-1:0]   cnt_value;
    logic [CNT_W-1:0]   cnt_next;
    logic               cnt_sat;
    logic [ISI_W-1:0]   timer_value;
    logic [ISI_W-1:0]   timer_next;
    logic               timer_sat;
    logic               unused_bits;

    assign rise_c    = spike & ~spike_q;
    assign wlen_in_c = (win_len == '0) ? WIN_W'(1) : win_len;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = COUNT;
            COUNT:   if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM decode: entry cycle counts nothing, en=0 in COUNT aborts silently
    always_comb begin
        active_c  = 1'b0;
        win_end_c = 1'b0;
        latch_c   = 1'b0;
        case (state_q)
            IDLE: begin
                latch_c = en;
            end
            COUNT: begin
                active_c  = en;
                win_end_c = en && (wc_q == (wlen_q - WIN_W'(1)));
                latch_c   = win_end_c;
            end
            default: begin
                active_c = 1'b0;
            end
        endcase
    end

    // Edge history, window length and position within the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q <= 1'b0;
            wlen_q  <= '0;
            wc_q    <= '0;
        end else begin
            spike_q <= spike;
            if (latch_c) begin
                wlen_q <= wlen_in_c;
            end
            if (!active_c || win_end_c) begin
                wc_q <= '0;
            end else begin
                wc_q <= wc_q + WIN_W'(1);
            end
        end
    end

    // Spike count of the open window; next_c already includes this cycle's edge
    lif_sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (~active_c | win_end_c),
        .start  (1'b0),
        .inc    (active_c & rise_c),
        .value  (cnt_value),
        .next_c (cnt_next),
        .sat_c  (cnt_sat)
    );

    // Cycles since the last edge, free-running across window boundaries
    lif_sat_counter #(
        .W (ISI_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (~active_c),
        .start  (active_c & rise_c),
        .inc    (active_c),
        .value  (timer_value),
        .next_c (timer_next),
        .sat_c  (timer_sat)
    );

    assign unused_bits = ^{cnt_value, timer_next, timer_sat};

    // has_prev gates the first edge after entry, which has no interval to report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_prev_q <= 1'b0;
        end else if (!active_c) begin
            has_prev_q <= 1'b0;
        end else if (rise_c) begin
            has_prev_q <= 1'b1;
        end
    end

    // Result registers and one-cycle strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate       <= '0;
            rate_sat   <= 1'b0;
            rate_valid <= 1'b0;
            isi        <= '0;
            isi_valid  <= 1'b0;
        end else begin
            rate_valid <= win_end_c;
            isi_valid  <= active_c & rise_c & has_prev_q;
            if (win_end_c) begin
                rate     <= cnt_next;
                rate_sat <= cnt_sat;
            end
            if (active_c && rise_c && has_prev_q) begin
                isi <= timer_value;
            end
        end
    end

endmodule

// File: tb/tb_lif_spike_decoder.sv
// Scoreboard bench for lif_spike_decoder: timestamp model plus per-scenario expectation table.
module tb_lif_spike_decoder;

    localparam int unsigned WIN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             spike;
    logic [WIN_W-1:0] win_len;

    logic [7:0] rate;
    logic       rate_valid;
    logic       rate_sat;
    logic [7:0] isi;
    logic       isi_valid;

    logic [2:0] rate3;
    logic       rate_valid3;
    logic       rate_sat3;
    logic [7:0] isi3;
    logic       isi_valid3;

    lif_spike_decoder #(.CNT_W(8), .WIN_W(8), .ISI_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spike(spike), .win_len(win_len),
        .rate(rate), .rate_valid(rate_valid), .rate_sat(rate_sat),
        .isi(isi), .isi_valid(isi_valid)
    );

    lif_spike_decoder #(.CNT_W(3), .WIN_W(8), .ISI_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .spike(spike), .win_len(win_len),
        .rate(rate3), .rate_valid(rate_valid3), .rate_sat(rate_sat3),
        .isi(isi3), .isi_valid(isi_valid3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string name;
        int    win_len;
        int    start;
        int    period;
        int    hold;
        int    cycles;
        int    exp_rate_n;
        int    exp_first_rate;
        int    exp_last_rate;
        int    exp_last_rate3;
        int    exp_last_sat3;
        int    exp_isi_n;
        int    exp_last_isi;
    } vec_t;

    vec_t vecs[6];

    int n_checks;
    int n_pass;

    int rq[$];
    int iq[$];

    int m_active, m_prev, m_wlen, m_pos, m_count, m_last_edge, m_cyc;

    int c_rate_n, c_first_rate, c_last_rate, c_last_rate3, c_last_sat3;
    int c_isi_n, c_last_isi;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int eff(input int wl);
        return (wl == 0) ? 1 : wl;
    endfunction

    function automatic int clip(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_reset();
        m_active = 0; m_prev = 0; m_wlen = 1; m_pos = 0;
        m_count = 0; m_last_edge = -1;
        rq.delete();
        iq.delete();
    endtask

    // Reference: raw edge count per window and timestamp differences between edges
    task automatic model_tick();
        bit rise;
        rise = spike && (m_prev == 0);
        if (m_active != 0 && en) begin
            if (rise) begin
                m_count++;
                if (m_last_edge >= 0) iq.push_back(clip(m_cyc - m_last_edge, 255));
                m_last_edge = m_cyc;
            end
            if (m_pos == m_wlen - 1) begin
                rq.push_back(m_count);
                m_count = 0;
                m_pos   = 0;
                m_wlen  = eff(int'(win_len));
            end else begin
                m_pos++;
            end
        end else if (m_active != 0) begin
            m_active = 0; m_count = 0; m_pos = 0; m_last_edge = -1;
        end else if (en) begin
            m_active = 1; m_wlen = eff(int'(win_len)); m_pos = 0;
            m_count = 0; m_last_edge = -1;
        end
        m_prev = int'(spike);
        m_cyc++;
    endtask

    task automatic monitor();
        bit exp_rv;
        bit exp_iv;
        int e;
        exp_rv = rq.size() > 0;
        exp_iv = iq.size() > 0;
        chk("rate_valid", int'(rate_valid), int'(exp_rv));
        chk("rate_valid3", int'(rate_valid3), int'(exp_rv));
        if (exp_rv) begin
            e = rq.pop_front();
            if (rate_valid) begin
                chk("rate", int'(rate), clip(e, 255));
                chk("rate_sat", int'(rate_sat), int'(e >= 255));
                chk("rate3", int'(rate3), clip(e, 7));
                chk("rate_sat3", int'(rate_sat3), int'(e >= 7));
                c_rate_n++;
                if (c_rate_n == 1) c_first_rate = int'(rate);
                c_last_rate  = int'(rate);
                c_last_rate3 = int'(rate3);
                c_last_sat3  = int'(rate_sat3);
            end
        end
        chk("isi_valid", int'(isi_valid), int'(exp_iv));
        chk("isi_valid3", int'(isi_valid3), int'(exp_iv));
        if (exp_iv) begin
            e = iq.pop_front();
            if (isi_valid) begin
                chk("isi", int'(isi), e);
                chk("isi3", int'(isi3), e);
                c_isi_n++;
                c_last_isi = int'(isi);
            end
        end
    endtask

    task automatic step(input bit e, input bit s, input int w);
        @(negedge clk);
        en      = e;
        spike   = s;
        win_len = WIN_W'(w);
        model_tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic clear_counts();
        c_rate_n = 0; c_first_rate = -1; c_last_rate = -1; c_last_rate3 = -1;
        c_last_sat3 = -1; c_isi_n = 0; c_last_isi = -1;
    endtask

    // k=0 is the IDLE entry cycle; the scenario closes with two en=0 cycles
    task automatic run_case(input vec_t v);
        bit s;
        clear_counts();
        for (int k = 0; k < v.cycles; k++) begin
            s = (k >= v.start) && (((k - v.start) % v.period) < v.hold);
            step(1'b1, s, v.win_len);
        end
        step(1'b0, 1'b0, v.win_len);
        step(1'b0, 1'b0, v.win_len);
        chk({v.name, "/rate_n"}, c_rate_n, v.exp_rate_n);
        chk({v.name, "/first_rate"}, c_first_rate, v.exp_first_rate);
        chk({v.name, "/last_rate"}, c_last_rate, v.exp_last_rate);
        chk({v.name, "/last_rate3"}, c_last_rate3, v.exp_last_rate3);
        chk({v.name, "/last_sat3"}, c_last_sat3, v.exp_last_sat3);
        chk({v.name, "/isi_n"}, c_isi_n, v.exp_isi_n);
        if (v.exp_last_isi >= 0) chk({v.name, "/last_isi"}, c_last_isi, v.exp_last_isi);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/rate"}, int'(rate), 0);
        chk({tag, "/rate_valid"}, int'(rate_valid), 0);
        chk({tag, "/rate_sat"}, int'(rate_sat), 0);
        chk({tag, "/isi"}, int'(isi), 0);
        chk({tag, "/isi_valid"}, int'(isi_valid), 0);
        chk({tag, "/rate3"}, int'(rate3), 0);
    endtask

    initial begin
        vec_t v;
        n_checks = 0; n_pass = 0; m_cyc = 0;
        rst_n = 1'b1; en = 1'b0; spike = 1'b0; win_len = '0;
        model_reset();
        clear_counts();

        //          name           wl  st per hold cyc  rn first last l3 s3 in  lisi
        vecs[0] = '{"c1_period3",   10, 1, 3,    1, 41,  4, 4,    4,   4, 0, 13, 3};
        vecs[1] = '{"c2_held",      20, 1, 1000, 5, 21,  1, 1,    1,   1, 0, 0,  -1};
        vecs[2] = '{"c3_sat",       16, 1, 2,    1, 17,  1, 8,    8,   7, 1, 7,  2};
        vecs[3] = '{"c4_wlen0",     0,  1, 2,    1, 10,  9, 1,    1,   1, 0, 4,  2};
        vecs[4] = '{"c6_isi_sat",   100,1, 300,  1, 602, 6, 1,    0,   0, 0, 2,  255};
        vecs[5] = '{"c7_isi_254",   255,1, 254,  1, 256, 1, 2,    2,   2, 0, 1,  254};

        #1 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 6; i++) run_case(vecs[i]);

        // Abort at wc=5 after two edges: rate keeps c7's value of 2
        clear_counts();
        step(1'b1, 1'b0, 10);
        step(1'b1, 1'b0, 10);
        step(1'b1, 1'b1, 10);
        step(1'b1, 1'b0, 10);
        step(1'b1, 1'b1, 10);
        step(1'b1, 1'b0, 10);
        step(1'b0, 1'b0, 10);
        step(1'b0, 1'b0, 10);
        chk("abort/rate_n", c_rate_n, 0);
        chk("abort/rate_hold", int'(rate), 2);
        chk("abort/isi_n", c_isi_n, 1);
        chk("abort/isi", int'(isi), 2);

        // Re-enable: fresh window, lone edge reports no interval
        v = '{"reenable", 10, 3, 1000, 1, 11, 1, 1, 1, 1, 0, 0, -1};
        run_case(v);
        chk("reenable/isi_hold", int'(isi), 2);

        // Asynchronous reset in the middle of a window
        step(1'b1, 1'b0, 10);
        step(1'b1, 1'b0, 10);
        step(1'b1, 1'b1, 10);
        step(1'b1, 1'b0, 10);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        @(negedge clk);
        en = 1'b0; spike = 1'b0;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 3);
        step(1'b0, 1'b0, 3);

        v = '{"post_reset", 3, 1, 1000, 1, 4, 1, 1, 1, 1, 0, 0, -1};
        run_case(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
